// File: rtl/nf_cpu_pkg.sv
// Shared definitions for the nf CPU front end.
//   fetch_state_e : fetch-stage FSM states
//   NF_PC_INC     : sequential PC step in bytes
//   NF_RESET_PC   : PC of the first fetch after reset
//   nf_align_word : clears the two byte-offset bits of an address
package nf_cpu_pkg;

  typedef enum logic [1:0] {
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_DROP,
    FETCH_HOLD
  } fetch_state_e;

  localparam int unsigned NF_PC_INC   = 4;
  localparam logic [31:0] NF_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] nf_align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/nf_pc_reg.sv
// Program counter register.
//   clk, resetn : clock, asynchronous active-low reset (pc <= RESET_PC)
//   load        : load load_addr (word-aligned on the way in); wins over inc
//   load_addr   : redirect target
//   inc         : advance pc by PC_INC, 32-bit modulo
//   pc          : current program counter
module nf_pc_reg
  import nf_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = NF_RESET_PC,
  parameter int unsigned PC_INC   = NF_PC_INC
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic [31:0] load_addr,
  input  logic        inc,
  output logic [31:0] pc
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= nf_align_word(load_addr);
    end else if (inc) begin
      pc <= pc + 32'(PC_INC);
    end
  end

endmodule

// File: rtl/nf_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem read at a
// time, and hands the instruction plus its PC to decode over valid/ready.
//   clk, resetn             : clock, asynchronous active-low reset
//   pc_src, pc_branch       : redirect strobe and target from the branch unit
//   imem_req, imem_addr     : read request / word address
//   imem_ack                : request accepted this cycle
//   imem_rvalid, imem_rdata : read response
//   instr_if, pc_if         : fetched instruction and its PC
//   instr_valid, instr_ready: decode handshake
module nf_fetch_unit
  import nf_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = NF_RESET_PC,
  parameter int unsigned PC_INC   = NF_PC_INC
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pc_src,
  input  logic [31:0] pc_branch,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_if,
  output logic [31:0] pc_if,
  output logic        instr_valid,
  input  logic        instr_ready
);

  fetch_state_e state_q, state_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, pcif_q;
  logic [31:0]  pc;
  logic         pc_inc;
  logic         capture;

  nf_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_INC   (PC_INC)
  ) u_pc_reg (
    .clk       (clk),
    .resetn    (resetn),
    .load      (pc_src),
    .load_addr (pc_branch),
    .inc       (pc_inc),
    .pc        (pc)
  );

  // A redirect always reloads the PC; the state logic only decides what to do
  // with the transaction in flight.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    pc_inc  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      FETCH_REQ: begin
        if (pc_src) begin
          state_d = imem_ack ? FETCH_DROP : FETCH_REQ;
        end else if (imem_ack) begin
          state_d = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (pc_src) begin
          // Data arriving with the redirect is stale; nothing left to drop.
          state_d = imem_rvalid ? FETCH_REQ : FETCH_DROP;
        end else if (imem_rvalid) begin
          capture = 1'b1;
          pc_inc  = 1'b1;
          valid_d = 1'b1;
          state_d = FETCH_HOLD;
        end
      end
      FETCH_DROP: begin
        // A redirect here only moves the PC; the pending response still drains.
        if (imem_rvalid) begin
          state_d = FETCH_REQ;
        end
      end
      FETCH_HOLD: begin
        if (pc_src || instr_ready) begin
          valid_d = 1'b0;
          state_d = FETCH_REQ;
        end
      end
      default: state_d = FETCH_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= FETCH_REQ;
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      pcif_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      if (capture) begin
        instr_q <= imem_rdata;
        pcif_q  <= pc;
      end
    end
  end

  // Gate with resetn so no request is visible while reset is held.
  assign imem_req    = resetn && (state_q == FETCH_REQ);
  assign imem_addr   = pc;
  assign instr_if    = instr_q;
  assign pc_if       = pcif_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_nf_fetch_unit.sv
// Bench for nf_fetch_unit: vector table, hand-written corner sequences and a
// randomized run against a transaction-level model of the fetch stage.
module tb_nf_fetch_unit;
  import nf_cpu_pkg::*;

  localparam logic [31:0] XORK = 32'hA5A5_A5A5;

  logic        clk;
  logic        resetn;
  logic        pc_src;
  logic [31:0] pc_branch;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_if;
  logic [31:0] pc_if;
  logic        instr_valid;
  logic        instr_ready;

  nf_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .PC_INC   (4)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .pc_src      (pc_src),
    .pc_branch   (pc_branch),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_if    (instr_if),
    .pc_if       (pc_if),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h, want %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Responses are legal only while a read is outstanding. The first edge after
  // reset release is exempt: a late response from before reset is ignored.
  int unsigned since_rst;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      since_rst <= 0;
    end else begin
      if (since_rst >= 1 && imem_rvalid) begin
        assert (!(imem_req || instr_valid))
        else $error("protocol: imem_rvalid with no read outstanding");
      end
      if (since_rst < 3) since_rst <= since_rst + 1;
    end
  end

  // Reference model: a request slot (in flight, and whether its data is still
  // wanted) plus a one-entry output buffer for decode.
  logic [31:0] m_pc, m_instr, m_pcif;
  bit          m_infl, m_keep, m_held;

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  task automatic m_reset();
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_pcif  = 32'h0;
    m_infl  = 0;
    m_keep  = 0;
    m_held  = 0;
  endtask

  task automatic m_clock(input bit src, input logic [31:0] br, input bit ack, input bit rv,
                         input logic [31:0] rd, input bit rdy);
    if (m_held) begin
      if (src || rdy) m_held = 0;
    end else if (!m_infl) begin
      if (ack) begin
        m_infl = 1;
        m_keep = !src;
      end
    end else begin
      if (src) m_keep = 0;
      if (rv) begin
        m_infl = 0;
        if (m_keep) begin
          m_held  = 1;
          m_instr = rd;
          m_pcif  = m_pc;
          m_pc    = m_pc + 32'd4;
        end
      end
    end
    if (src) m_pc = align(br);
  endtask

  task automatic m_check();
    bit exp_req;
    exp_req = !m_infl && !m_held;
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_held});
    chk("instr_if", instr_if, m_instr);
    chk("pc_if", pc_if, m_pcif);
  endtask

  // Called at a negedge: drive, clock, advance model, check at next negedge.
  task automatic step(input bit src, input logic [31:0] br, input bit ack, input bit rv,
                      input logic [31:0] rd, input bit rdy);
    pc_src      = src;
    pc_branch   = br;
    imem_ack    = ack;
    imem_rvalid = rv;
    imem_rdata  = rd;
    instr_ready = rdy;
    @(posedge clk);
    m_clock(src, br, ack, rv, rd, rdy);
    @(negedge clk);
    m_check();
  endtask

  task automatic idle_inputs();
    pc_src      = 1'b0;
    pc_branch   = 32'h0;
    imem_ack    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
  endtask

  // Asserts reset asynchronously, checks outputs at once, releases at a negedge.
  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    #1;
    chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr_if", instr_if, 32'h0);
    chk("rst_pc_if", pc_if, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    m_reset();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    m_check();
  endtask

  typedef struct {
    logic        src;
    logic [31:0] br;
    logic        ack;
    logic        rv;
    logic [31:0] rd;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pcif;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int unsigned mem_cnt;
    bit          mem_busy;
    logic [31:0] mem_addr;

    // Zero-wait fetches of 0x0/0x4/0x8, redirect with the rvalid of 0xC,
    // redirect in the ack cycle of 0x100 (drained in DROP), then 0x200.
    //        src br          ack rv  rd            rdy  req addr         vld pc_if        instr
    tbl[0]  = '{0, 32'h0,      1, 0, 32'h0,         1,   1, 32'h0000_0000, 0, 32'h0,       32'h0};
    tbl[1]  = '{0, 32'h0,      0, 1, 32'hA5A5_A5A5, 1,   0, 32'h0,         0, 32'h0,       32'h0};
    tbl[2]  = '{0, 32'h0,      0, 0, 32'h0,         1,   0, 32'h0,         1, 32'h0,       32'hA5A5_A5A5};
    tbl[3]  = '{0, 32'h0,      1, 0, 32'h0,         1,   1, 32'h0000_0004, 0, 32'h0,       32'h0};
    tbl[4]  = '{0, 32'h0,      0, 1, 32'hA5A5_A5A1, 1,   0, 32'h0,         0, 32'h0,       32'h0};
    tbl[5]  = '{0, 32'h0,      0, 0, 32'h0,         1,   0, 32'h0,         1, 32'h4,       32'hA5A5_A5A1};
    tbl[6]  = '{0, 32'h0,      1, 0, 32'h0,         1,   1, 32'h0000_0008, 0, 32'h0,       32'h0};
    tbl[7]  = '{0, 32'h0,      0, 1, 32'hA5A5_A5AD, 1,   0, 32'h0,         0, 32'h0,       32'h0};
    tbl[8]  = '{0, 32'h0,      0, 0, 32'h0,         1,   0, 32'h0,         1, 32'h8,       32'hA5A5_A5AD};
    tbl[9]  = '{0, 32'h0,      1, 0, 32'h0,         1,   1, 32'h0000_000C, 0, 32'h0,       32'h0};
    tbl[10] = '{1, 32'h100,    0, 1, 32'hA5A5_A5A9, 1,   0, 32'h0,         0, 32'h0,       32'h0};
    tbl[11] = '{1, 32'h200,    1, 0, 32'h0,         1,   1, 32'h0000_0100, 0, 32'h0,       32'h0};
    tbl[12] = '{0, 32'h0,      0, 1, 32'hA5A5_A4A5, 1,   0, 32'h0,         0, 32'h0,       32'h0};
    tbl[13] = '{0, 32'h0,      1, 0, 32'h0,         1,   1, 32'h0000_0200, 0, 32'h0,       32'h0};
    tbl[14] = '{0, 32'h0,      0, 1, 32'hA5A5_A7A5, 1,   0, 32'h0,         0, 32'h0,       32'h0};
    tbl[15] = '{0, 32'h0,      0, 0, 32'h0,         1,   0, 32'h0,         1, 32'h200,     32'hA5A5_A7A5};
    tbl[16] = '{0, 32'h0,      0, 0, 32'h0,         0,   1, 32'h0000_0204, 0, 32'h0,       32'h0};

    resetn = 1'b0;
    idle_inputs();
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 17; i++) begin
      chk($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].e_valid});
      if (tbl[i].e_valid) begin
        chk($sformatf("vec%0d_pc_if", i), pc_if, tbl[i].e_pcif);
        chk($sformatf("vec%0d_instr", i), instr_if, tbl[i].e_instr);
      end
      step(tbl[i].src, tbl[i].br, tbl[i].ack, tbl[i].rv, tbl[i].rd, tbl[i].rdy);
    end

    // Slow memory: ack at N, rvalid at N+3, instr_valid from N+4.
    do_reset();
    step(0, 32'h0, 1, 0, 32'h0, 0);
    for (int i = 0; i < 2; i++) begin
      chk("wait_no_req", {31'b0, imem_req}, 32'h0);
      step(0, 32'h0, 0, 0, 32'h0, 0);
    end
    chk("wait_no_valid", {31'b0, instr_valid}, 32'h0);
    step(0, 32'h0, 0, 1, XORK, 0);
    chk("lat_valid", {31'b0, instr_valid}, 32'h1);
    chk("lat_pc_if", pc_if, 32'h0);

    // Stall in HOLD, then redirect to 0x40 drops the held instruction.
    for (int i = 0; i < 5; i++) begin
      step(0, 32'h0, 0, 0, 32'h0, 0);
      chk("stall_instr", instr_if, XORK);
      chk("stall_pc_if", pc_if, 32'h0);
      chk("stall_no_req", {31'b0, imem_req}, 32'h0);
    end
    step(1, 32'h40, 0, 0, 32'h0, 1);
    chk("redir_valid", {31'b0, instr_valid}, 32'h0);
    chk("redir_addr", imem_addr, 32'h40);
    step(0, 32'h0, 1, 0, 32'h0, 0);
    step(0, 32'h0, 0, 1, 32'h40 ^ XORK, 0);
    chk("redir_pc_if", pc_if, 32'h40);

    // Misaligned redirect near the top of memory, then wrap to 0.
    step(1, 32'hFFFF_FFFE, 0, 0, 32'h0, 0);
    chk("align_addr", imem_addr, 32'hFFFF_FFFC);
    step(0, 32'h0, 1, 0, 32'h0, 0);
    step(0, 32'h0, 0, 1, 32'h1234_5678, 0);
    chk("top_pc_if", pc_if, 32'hFFFF_FFFC);
    step(0, 32'h0, 0, 0, 32'h0, 1);
    chk("wrap_addr", imem_addr, 32'h0);

    // Reset while in WAIT, then a late response straight after release.
    step(0, 32'h0, 1, 0, 32'h0, 0);
    #2;
    do_reset();
    step(0, 32'h0, 0, 1, 32'hDEAD_BEEF, 0);
    chk("late_rv_req", {31'b0, imem_req}, 32'h1);
    chk("late_rv_valid", {31'b0, instr_valid}, 32'h0);
    step(0, 32'h0, 1, 0, 32'h0, 0);
    step(0, 32'h0, 0, 1, XORK, 0);
    chk("post_rst_pc_if", pc_if, 32'h0);
    chk("post_rst_instr", instr_if, XORK);

    // Randomized run against the model with a 1..3 cycle memory.
    do_reset();
    mem_busy = 0;
    mem_cnt  = 0;
    mem_addr = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      bit          src, ack, rv, rdy;
      logic [31:0] br, rd;
      src = ($urandom % 10) == 0;
      br  = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      rv  = 0;
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          rv       = 1;
          mem_busy = 0;
        end
      end
      ack = !m_infl && !m_held && (($urandom % 3) != 0);
      rd  = rv ? (mem_addr ^ XORK) : $urandom;
      if (ack) begin
        mem_busy = 1;
        mem_cnt  = $urandom_range(1, 3);
        mem_addr = m_pc;
      end
      rdy = ($urandom % 10) < 7;
      step(src, br, ack, rv, rd, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
